// File: rtl/drum_step_sequencer.sv
// Multi-track drum step sequencer: pattern grid, tempo divider, loop length,
// per-track mute and a row-per-cycle bulk clear.
module drum_step_sequencer #(
  parameter int NUM_TRACKS = 4,
  parameter int NUM_STEPS  = 16,
  parameter int STEP_W     = 4,
  parameter int TRK_W      = 2,
  parameter int TEMPO_W    = 27
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic                  play,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  toggle,
  input  logic [TRK_W-1:0]      edit_track,
  input  logic [STEP_W-1:0]     edit_step,
  input  logic [TEMPO_W-1:0]    tempo_div,
  input  logic [STEP_W-1:0]     loop_len,
  input  logic [NUM_TRACKS-1:0] mute,
  output logic [NUM_TRACKS-1:0] trig,
  output logic [STEP_W-1:0]     cur_step,
  output logic                  playing,
  output logic                  busy,
  output logic [NUM_STEPS-1:0]  track_view
);

  // state | meaning
  // IDLE  | stopped at step 0, pattern editable
  // PLAY  | stepping through the pattern, firing triggers
  // CLEAR | zeroing one track row per cycle, all requests ignored
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [STEP_W-1:0]     cur_step_q, cur_step_d;
  logic [TEMPO_W-1:0]    tick_q, tick_d;
  logic [NUM_TRACKS-1:0] trig_q, trig_d;
  logic                  playing_q, playing_d;
  logic                  busy_q, busy_d;
  logic [TRK_W-1:0]      clear_idx_q, clear_idx_d;
  logic [NUM_STEPS-1:0]  pattern_q [NUM_TRACKS];
  logic [NUM_STEPS-1:0]  pattern_d [NUM_TRACKS];

  // Lookup masks of legal indices avoid range compares that fold to constants
  logic [(1<<TRK_W)-1:0]  trk_mask;
  logic [(1<<STEP_W)-1:0] step_mask;

  for (genvar g = 0; g < (1 << TRK_W); g++) begin : g_trk_mask
    assign trk_mask[g] = (g < NUM_TRACKS);
  end
  for (genvar g = 0; g < (1 << STEP_W); g++) begin : g_step_mask
    assign step_mask[g] = (g < NUM_STEPS);
  end

  logic                  trk_ok, step_ok, toggle_en, advance;
  logic [STEP_W-1:0]     loop_end, next_step, step_sel;
  logic [TEMPO_W-1:0]    tick_last;
  logic [NUM_TRACKS-1:0] trig_row;

  always_comb begin
    trk_ok    = trk_mask[edit_track];
    step_ok   = step_mask[edit_step];
    loop_end  = step_mask[loop_len] ? loop_len : STEP_W'(NUM_STEPS - 1);
    next_step = (cur_step_q >= loop_end) ? '0 : cur_step_q + 1'b1;
    tick_last = (tempo_div == '0) ? '0 : tempo_div - 1'b1;
    advance   = (tick_q >= tick_last);
    step_sel  = (play && !stop) ? '0 : next_step;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      trig_row[t] = pattern_q[t][step_sel] & ~mute[t];
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_step_d  = cur_step_q;
    tick_d      = tick_q;
    trig_d      = '0;
    busy_d      = busy_q;
    clear_idx_d = clear_idx_q;
    toggle_en   = 1'b0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      pattern_d[t] = pattern_q[t];
    end

    case (state_q)
      IDLE, PLAY: begin
        if (clear) begin
          state_d     = CLEAR;
          busy_d      = 1'b1;
          clear_idx_d = '0;
          cur_step_d  = '0;
          tick_d      = '0;
        end else if (stop) begin
          state_d    = IDLE;
          cur_step_d = '0;
          tick_d     = '0;
        end else if (play) begin
          state_d    = PLAY;
          cur_step_d = '0;
          tick_d     = '0;
          trig_d     = trig_row;
        end else begin
          toggle_en = toggle;
          if (state_q == PLAY) begin
            if (advance) begin
              tick_d     = '0;
              cur_step_d = next_step;
              trig_d     = trig_row;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
      end
      CLEAR: begin
        for (int t = 0; t < NUM_TRACKS; t++) begin
          if (clear_idx_q == TRK_W'(t)) pattern_d[t] = '0;
        end
        if (clear_idx_q == TRK_W'(NUM_TRACKS - 1)) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          clear_idx_d = '0;
        end else begin
          clear_idx_d = clear_idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Trigger row above is taken from pattern_q, so a same-edge toggle fires the old bit
    for (int t = 0; t < NUM_TRACKS; t++) begin
      if (toggle_en && trk_ok && step_ok && edit_track == TRK_W'(t)) begin
        pattern_d[t][edit_step] = ~pattern_q[t][edit_step];
      end
    end

    playing_d = (state_d == PLAY);
  end

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      state_q     <= IDLE;
      cur_step_q  <= '0;
      tick_q      <= '0;
      trig_q      <= '0;
      playing_q   <= 1'b0;
      busy_q      <= 1'b0;
      clear_idx_q <= '0;
      for (int t = 0; t < NUM_TRACKS; t++) begin
        pattern_q[t] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cur_step_q  <= cur_step_d;
      tick_q      <= tick_d;
      trig_q      <= trig_d;
      playing_q   <= playing_d;
      busy_q      <= busy_d;
      clear_idx_q <= clear_idx_d;
      for (int t = 0; t < NUM_TRACKS; t++) begin
        pattern_q[t] <= pattern_d[t];
      end
    end
  end

  assign trig       = trig_q;
  assign cur_step   = cur_step_q;
  assign playing    = playing_q;
  assign busy       = busy_q;
  assign track_view = trk_ok ? pattern_q[edit_track] : '0;

endmodule

// File: doc/drum_step_sequencer.md
Name: drum_step_sequencer

Overview:
- Parametrised multi-track step sequencer for the drum machine: an NUM_TRACKS x NUM_STEPS pattern grid, a programmable tempo divider and a loop-length control.
- Emits one-cycle trigger pulses per track to the sound/LED logic.
- Sits between the debounced button/switch decoders and the drum voice generators and 7-segment step display in the top level.
- Generalises the fixed drum machine to any track/step count, with mute, loop length and bulk clear.

Parameters:
- NUM_TRACKS, 4, number of drum tracks (1..16)
- NUM_STEPS, 16, steps per pattern (2..64)
- STEP_W, 4, width of step index; must satisfy 2^STEP_W >= NUM_STEPS
- TRK_W, 2, width of track index; must satisfy 2^TRK_W >= NUM_TRACKS
- TEMPO_W, 27, width of tempo divider

Ports:
- ClkPort, in, 1, system clock
- Reset, in, 1, synchronous active-high reset
- play, in, 1, one-cycle pulse; start, or restart at step 0
- stop, in, 1, one-cycle pulse; stop and rewind
- clear, in, 1, one-cycle pulse; erase whole pattern
- toggle, in, 1, one-cycle pulse; invert cell [edit_track][edit_step]
- edit_track, in, TRK_W, track selected for edit/view
- edit_step, in, STEP_W, step selected for edit
- tempo_div, in, TEMPO_W, clock cycles per step; 0 is treated as 1
- loop_len, in, STEP_W, index of last step played (loop end)
- mute, in, NUM_TRACKS, per-track trigger mask, 1 = muted
- trig, out, NUM_TRACKS, one-cycle trigger per track at each step start
- cur_step, out, STEP_W, step currently playing
- playing, out, 1, high in PLAY state
- busy, out, 1, high while a clear is in progress
- track_view, out, NUM_STEPS, pattern row of edit_track, for LEDs

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, cur_step=0, tick_cnt=0, trig=0, playing=0, busy=0, clear_idx=0. All pattern bits are 0 after reset.
- States and transitions:
  - IDLE: play -> PLAY; clear -> CLEAR.
  - PLAY: stop -> IDLE; play -> PLAY restart; clear -> CLEAR.
  - CLEAR: after NUM_TRACKS cycles -> IDLE.
- Input priority in the same cycle: Reset > clear > stop > play > toggle.
- Play start/restart:
  - At the edge sampling play: cur_step<=0, tick_cnt<=0, trig<=pattern[*][0] & ~mute.
  - trig is therefore visible in the cycle after play.
- Step advance in PLAY:
  - tick_cnt counts 0..max(tempo_div,1)-1.
  - At the edge where tick_cnt==max(tempo_div,1)-1: tick_cnt<=0, cur_step<=next, trig<=pattern[*][next] & ~mute.
  - next = 0 if cur_step>=loop_len, otherwise cur_step+1.
  - On every other edge, trig<=0. Trig period is exactly tempo_div cycles; tempo_div=1 gives trig every cycle.
- loop_len:
  - Sampled at each advance. Shrinking it below cur_step wraps to 0 at the next advance.
  - Values >= NUM_STEPS are clamped to NUM_STEPS-1.
- tempo_div changes take effect at the next compare. No restart of the current step.
- mute applies at trig generation only; the pattern is unaffected.
- Stop: next edge state=IDLE, cur_step=0, tick_cnt=0, trig=0.
- toggle:
  - Accepted in IDLE and PLAY, ignored in CLEAR.
  - Out-of-range edit_track/edit_step (>= NUM_TRACKS/NUM_STEPS) is ignored.
  - Pattern bit flips at the sampling edge.
  - If the toggled cell is the one being triggered on that same edge, trig uses the pre-toggle value.
- clear:
  - Enters CLEAR with busy=1, playing=0, trig=0, cur_step=0.
  - Zeroes one track row per cycle, clear_idx 0..NUM_TRACKS-1, then IDLE with busy=0.
  - play/stop/toggle/clear during CLEAR are ignored. Reset mid-clear aborts to IDLE, and the pattern is zeroed by reset.
- track_view: combinational read of pattern row edit_track; all zeros if out of range.
- playing: registered, equals (state==PLAY).
- Storage: NUM_TRACKS x NUM_STEPS flip-flops; no RAM inference required.

Test Plan (NUM_TRACKS=4, NUM_STEPS=8, STEP_W=3, TRK_W=2):
- Reset, then toggle cells (t0,s0), (t1,s2), (t3,s7); tempo_div=4, loop_len=7, play -> trig=4'b0001 the cycle after play; trig=4'b0010 8 cycles later (cur_step=2); trig=4'b1000 at step 7; wraps to step 0 with trig=4'b0001 exactly 32 cycles after the first trig.
- Same pattern, loop_len=3 -> cur_step sequence 0,1,2,3,0; t3 never fires. Change loop_len to 1 while cur_step=3 -> next step is 0.
- mute=4'b0001 during play -> step 0 produces trig=0 while cur_step still advances. Unmute -> trig=4'b0001 on the next pass.
- Pulse stop mid-step -> next cycle playing=0, cur_step=0, trig=0. Simultaneous play+stop -> IDLE.
- Toggle (t1,s2) on the exact edge step 2 fires -> trig[1]=1 (old value); track_view for edit_track=1 then reads 8'b0000_0000.
- clear while playing -> busy=1 for exactly 4 cycles; play and toggle pulses during busy ignored; afterwards all track_view=0, playing=0. tempo_div=0 plus play -> trig every cycle per pattern.
